// File: rtl/debounce_btn_multi_if.sv
// rtl/debounce_btn_multi_if.sv - button pins and debounced outputs bundle
interface debounce_btn_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press_tick;
    logic [N_CH-1:0] release_tick;
    logic [N_CH-1:0] long_tick;

    modport master (
        output btn_in,
        input  level,
        input  press_tick,
        input  release_tick,
        input  long_tick
    );

    modport slave (
        input  btn_in,
        output level,
        output press_tick,
        output release_tick,
        output long_tick
    );
endinterface

// File: rtl/debounce_btn_multi.sv
// rtl/debounce_btn_multi.sv - multi-channel button debouncer with press/release/long-press ticks
module debounce_btn_multi #(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 1000000,
    parameter int CNT_W         = 20,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int HOLD_W        = 26,
    parameter int ACTIVE_LOW    = 0
) (
    input logic                 ckht,
    input logic                 rst_n,
    debounce_btn_multi_if.slave bus
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    localparam logic [CNT_W-1:0]  DB_LOAD   = CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic [N_CH-1:0] pin_pol;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] press_w;
    logic [N_CH-1:0] release_w;
    logic [N_CH-1:0] long_w;

    // Inverting ahead of the synchroniser keeps the reset value meaning "not pressed".
    assign pin_pol = (ACTIVE_LOW != 0) ? ~bus.btn_in : bus.btn_in;

    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= pin_pol;
            s     <= sync1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t            state;
        logic [CNT_W-1:0]  cnt;
        logic [HOLD_W-1:0] hold;
        logic              long_done;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;

        always_ff @(posedge ckht or negedge rst_n) begin
            if (!rst_n) begin
                state     <= ZERO;
                cnt       <= '0;
                hold      <= '0;
                long_done <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state)
                    ZERO: begin
                        if (s[i]) begin
                            cnt   <= DB_LOAD;
                            state <= WAIT1;
                        end
                    end
                    WAIT1: begin
                        if (!s[i]) begin
                            state <= ZERO;
                        end else if (cnt == '0) begin
                            state     <= ONE;
                            level_q   <= 1'b1;
                            press_q   <= 1'b1;
                            hold      <= '0;
                            long_done <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ONE: begin
                        if (!s[i]) begin
                            cnt   <= DB_LOAD;
                            state <= WAIT0;
                        end else if (!long_done) begin
                            if (hold == LONG_LAST) begin
                                long_q    <= 1'b1;
                                hold      <= '0;
                                long_done <= 1'b1;
                            end else begin
                                hold <= hold + 1'b1;
                            end
                        end else if (REPEAT_EN != 0) begin
                            if (hold == REP_LAST) begin
                                long_q <= 1'b1;
                                hold   <= '0;
                            end else begin
                                hold <= hold + 1'b1;
                            end
                        end
                    end
                    WAIT0: begin
                        // Hold stays frozen here so a release glitch does not advance long-press timing.
                        if (s[i]) begin
                            state <= ONE;
                        end else if (cnt == '0) begin
                            state     <= ZERO;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= ZERO;
                endcase
            end
        end

        assign level_w[i]   = level_q;
        assign press_w[i]   = press_q;
        assign release_w[i] = release_q;
        assign long_w[i]    = long_q;
    end

    assign bus.level        = level_w;
    assign bus.press_tick   = press_w;
    assign bus.release_tick = release_w;
    assign bus.long_tick    = long_w;
endmodule
